// File: rtl/dmem_issue_unit.sv
// dmem_issue_unit: EXE-stage data-memory translation, exception check and SRAM-like request issue with flush drain
module dmem_issue_unit #(
  parameter int NUM_DMW   = 2,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic                 op_wr,
  input  logic [1:0]           op_size,
  input  logic [31:0]          op_vaddr,
  input  logic [31:0]          op_wdata,
  input  logic [1:0]           csr_plv,
  input  logic                 csr_direct,
  input  logic [3*NUM_DMW-1:0] dmw_vseg,
  input  logic [3*NUM_DMW-1:0] dmw_pseg,
  input  logic [NUM_DMW-1:0]   dmw_plv0,
  input  logic [NUM_DMW-1:0]   dmw_plv3,
  output logic [18:0]          tlb_vppn,
  output logic                 tlb_va_bit12,
  input  logic                 tlb_found,
  input  logic [19:0]          tlb_ppn,
  input  logic [5:0]           tlb_ps,
  input  logic [1:0]           tlb_plv,
  input  logic                 tlb_v,
  input  logic                 tlb_d,
  output logic                 ex_valid,
  output logic [5:0]           ex_ecode,
  output logic [31:0]          ex_badv,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [1:0]           mem_size,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_addr_ok,
  input  logic                 mem_data_ok,
  input  logic [31:0]          mem_rdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic [CNT_W-1:0]     inflight,
  output logic                 busy
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_next;
  logic [CNT_W-1:0] drop_cnt, inflight_next;
  logic dmw_hit, mapped, ale, exc, accept, addr_acc, data_acc;
  logic [31:0] dmw_pa, pa, wdata;
  logic [5:0] ecode;
  logic [3:0] wstrb;
  logic [1:0] size;
  assign tlb_vppn     = op_vaddr[31:13];
  assign tlb_va_bit12 = op_vaddr[12];
  assign op_ready     = (state == IDLE) && (inflight < CNT_W'(MAX_OUTST)) && !flush;
  assign accept       = op_valid && op_ready;
  assign mem_req      = (state == REQ);
  assign busy         = (inflight != '0) || (state == REQ);
  // iterate downward so the lowest-index hitting window wins
  always_comb begin
    dmw_hit = 1'b0;
    dmw_pa  = '0;
    for (int i = NUM_DMW - 1; i >= 0; i--)
      if (op_vaddr[31:29] == dmw_vseg[3*i +: 3] &&
          ((csr_plv == 2'd0 && dmw_plv0[i]) || (csr_plv == 2'd3 && dmw_plv3[i]))) begin
        dmw_hit = 1'b1;
        dmw_pa  = {dmw_pseg[3*i +: 3], op_vaddr[28:0]};
      end
  end
  always_comb begin
    mapped = !csr_direct && !dmw_hit;
    pa     = csr_direct ? op_vaddr : dmw_hit ? dmw_pa :
             (tlb_ps == 6'd22) ? {tlb_ppn[19:10], op_vaddr[21:0]} : {tlb_ppn, op_vaddr[11:0]};
    ale    = (op_size == 2'b01 && op_vaddr[0]) || (op_size[1] && op_vaddr[1:0] != 2'b00);
    ecode  = ale                   ? 6'h09 :
             !mapped               ? 6'h00 :
             !tlb_found            ? 6'h3F :
             !tlb_v                ? (op_wr ? 6'h02 : 6'h01) :
             (tlb_plv < csr_plv)   ? 6'h07 :
             (op_wr && !tlb_d)     ? 6'h04 : 6'h00;
    exc    = (ecode != 6'h00);
    size   = op_size[1] ? 2'b10 : op_size;
    wstrb  = !op_wr ? 4'b0000 : size == 2'b00 ? 4'b0001 << op_vaddr[1:0] :
             size == 2'b01 ? (op_vaddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata  = size == 2'b00 ? {4{op_wdata[7:0]}} : size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
  end
  always_comb begin
    state_next = state;
    if (state == IDLE && accept && !exc) state_next = REQ;
    if (state == REQ && (mem_addr_ok || flush)) state_next = IDLE;
  end
  // a response with nothing in flight is ignored by the counters
  assign addr_acc      = (state == REQ) && mem_addr_ok;
  assign data_acc      = mem_data_ok && (inflight != '0);
  assign inflight_next = inflight + CNT_W'(addr_acc) - CNT_W'(data_acc);
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      inflight  <= '0;
      drop_cnt  <= '0;
      ex_valid  <= 1'b0;
      ex_ecode  <= '0;
      ex_badv   <= '0;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      inflight  <= inflight_next;
      ex_valid  <= accept && exc;
      rsp_valid <= data_acc && drop_cnt == '0 && !flush;
      if (flush) drop_cnt <= inflight_next;
      else if (data_acc && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      if (data_acc && drop_cnt == '0 && !flush) rsp_rdata <= mem_rdata;
      if (accept && exc) begin
        ex_ecode <= ecode;
        ex_badv  <= op_vaddr;
      end
      if (accept && !exc) begin
        mem_wr    <= op_wr;
        mem_size  <= size;
        mem_wstrb <= wstrb;
        mem_addr  <= pa;
        mem_wdata <= wdata;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset) assert (!(mem_data_ok && inflight == '0));
endmodule

// File: tb/tb_dmem_issue_unit.sv
// tb_dmem_issue_unit: directed self-checking bench for dmem_issue_unit
module tb_dmem_issue_unit;
  logic clk = 0, reset = 1, flush = 0;
  logic op_valid = 0, op_ready, op_wr = 0;
  logic [1:0] op_size = 0;
  logic [31:0] op_vaddr = 0, op_wdata = 0;
  logic [1:0] csr_plv = 0;
  logic csr_direct = 1;
  logic [5:0] dmw_vseg = 0, dmw_pseg = 0;
  logic [1:0] dmw_plv0 = 0, dmw_plv3 = 0;
  logic [18:0] tlb_vppn;
  logic tlb_va_bit12;
  logic tlb_found = 1, tlb_v = 1, tlb_d = 1;
  logic [19:0] tlb_ppn = 0;
  logic [5:0] tlb_ps = 6'd12;
  logic [1:0] tlb_plv = 3;
  logic ex_valid;
  logic [5:0] ex_ecode;
  logic [31:0] ex_badv;
  logic mem_req, mem_wr;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0] inflight;
  logic busy;
  int checks = 0, errors = 0;

  dmem_issue_unit #(.NUM_DMW(2), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
    .op_wr(op_wr), .op_size(op_size), .op_vaddr(op_vaddr), .op_wdata(op_wdata),
    .csr_plv(csr_plv), .csr_direct(csr_direct), .dmw_vseg(dmw_vseg), .dmw_pseg(dmw_pseg),
    .dmw_plv0(dmw_plv0), .dmw_plv3(dmw_plv3), .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12),
    .tlb_found(tlb_found), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps), .tlb_plv(tlb_plv),
    .tlb_v(tlb_v), .tlb_d(tlb_d), .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_badv(ex_badv),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] va, input logic [31:0] wd);
    op_valid = 1; op_wr = wr; op_size = sz; op_vaddr = va; op_wdata = wd;
    step();
    op_valid = 0;
  endtask

  task automatic ack();
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0;
  endtask

  task automatic resp(input logic [31:0] d);
    mem_data_ok = 1; mem_rdata = d;
    step();
    mem_data_ok = 0;
  endtask

  task automatic load_addr(input string tag, input logic [31:0] va, input logic [31:0] pa);
    issue(0, 2'b10, va, 0);
    check(tag, mem_addr, pa);
    ack();
    resp(32'h0);
  endtask

  initial begin
    step(); step();
    reset = 0;
    check("rst_mem_req", mem_req, 0);
    check("rst_inflight", inflight, 0);
    check("rst_busy", busy, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op_ready", op_ready, 1);

    // direct load word
    issue(0, 2'b10, 32'h1C000104, 0);
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h1C000104);
    check("t1_wstrb", mem_wstrb, 0);
    check("t1_size", mem_size, 2);
    check("t1_busy", busy, 1);
    ack();
    check("t1_req_drop", mem_req, 0);
    check("t1_inflight1", inflight, 1);
    resp(32'hDEADBEEF);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("t1_inflight0", inflight, 0);
    step();
    check("t1_rsp_pulse", rsp_valid, 0);

    // reserved size is a word store
    issue(1, 2'b11, 32'h00000100, 32'h11223344);
    check("rsv_size", mem_size, 2);
    check("rsv_wstrb", mem_wstrb, 4'hF);
    check("rsv_wdata", mem_wdata, 32'h11223344);
    ack(); resp(0);

    // DMW0 byte store, DMW1 overlaps with a different pseg and TLB misses
    csr_direct = 0; dmw_vseg = {3'd5, 3'd5}; dmw_pseg = {3'd7, 3'd0}; dmw_plv0 = 2'b11;
    tlb_found = 0;
    issue(1, 2'b00, 32'hA0000003, 32'h0000005A);
    check("t2_ex", ex_valid, 0);
    check("t2_addr", mem_addr, 32'h00000003);
    check("t2_wstrb", mem_wstrb, 4'b1000);
    check("t2_wdata", mem_wdata, 32'h5A5A5A5A);
    check("t2_wr", mem_wr, 1);
    issue(0, 2'b01, 32'hA0000002, 0);
    check("t2_pend_noaccept", mem_addr, 32'h00000003);
    ack(); resp(0);
    issue(1, 2'b01, 32'hA0000002, 32'h0000BEEF);
    check("t2_half_wstrb", mem_wstrb, 4'b1100);
    check("t2_half_wdata", mem_wdata, 32'hBEEFBEEF);
    ack(); resp(0);

    // TLB translation and exceptions
    dmw_plv0 = 0; tlb_found = 1; tlb_ppn = 20'h12345;
    load_addr("tlb_4k", 32'h00401234, 32'h12345234);
    tlb_ps = 6'd22;
    load_addr("tlb_4m", 32'h00401234, 32'h12001234);
    tlb_ps = 6'd12;
    issue(0, 2'b01, 32'h00400001, 0);
    check("ale_valid", ex_valid, 1);
    check("ale_ecode", ex_ecode, 6'h09);
    check("ale_badv", ex_badv, 32'h00400001);
    check("ale_noreq", mem_req, 0);
    step();
    check("ale_pulse", ex_valid, 0);
    tlb_v = 1; tlb_d = 0; tlb_plv = 0;
    issue(1, 2'b10, 32'h00400000, 0);
    check("pme_ecode", ex_ecode, 6'h04);
    check("pme_noreq", mem_req, 0);
    tlb_found = 0;
    issue(0, 2'b10, 32'h00400000, 0);
    check("tlbr_ecode", ex_ecode, 6'h3F);
    tlb_found = 1; tlb_v = 0;
    issue(0, 2'b10, 32'h00400000, 0);
    check("pil_ecode", ex_ecode, 6'h01);
    issue(1, 2'b10, 32'h00400000, 0);
    check("pis_ecode", ex_ecode, 6'h02);
    tlb_v = 1; csr_plv = 3;
    issue(0, 2'b10, 32'h00400000, 0);
    check("ppi_ecode", ex_ecode, 6'h07);
    csr_plv = 0; tlb_d = 1; csr_direct = 1;
    issue(0, 2'b11, 32'h00000102, 0);
    check("ale_direct", ex_ecode, 6'h09);
    check("ale_direct_v", ex_valid, 1);

    // fill to MAX_OUTST
    for (int i = 0; i < 4; i++) begin
      issue(0, 2'b10, 32'h100 + 32'(i * 4), 0);
      ack();
    end
    check("t4_inflight", inflight, 4);
    check("t4_ready0", op_ready, 0);
    resp(32'h1);
    check("t4_ready1", op_ready, 1);
    check("t4_inflight3", inflight, 3);
    for (int i = 0; i < 3; i++) resp(32'h2);
    check("t4_drained", inflight, 0);

    // flush drops three in-flight responses
    for (int i = 0; i < 3; i++) begin
      issue(0, 2'b10, 32'h200, 0);
      ack();
    end
    flush = 1; step(); flush = 0;
    for (int i = 0; i < 3; i++) begin
      resp(32'hBAD0 + 32'(i));
      check("t5_dropped", rsp_valid, 0);
    end
    check("t5_inflight0", inflight, 0);
    issue(0, 2'b10, 32'h300, 0); ack();
    resp(32'h12345678);
    check("t5_new_valid", rsp_valid, 1);
    check("t5_new_data", rsp_rdata, 32'h12345678);

    // flush in REQ, withdrawn and accepted cases
    issue(0, 2'b10, 32'h400, 0);
    flush = 1; step(); flush = 0;
    check("t6_withdrawn", mem_req, 0);
    check("t6_inflight0", inflight, 0);
    issue(0, 2'b10, 32'h404, 0);
    flush = 1; mem_addr_ok = 1; step(); flush = 0; mem_addr_ok = 0;
    check("t6_acc_inflight", inflight, 1);
    check("t6_acc_noreq", mem_req, 0);
    resp(32'hCAFE);
    check("t6_acc_dropped", rsp_valid, 0);
    issue(0, 2'b10, 32'h408, 0); ack();
    resp(32'hF00D);
    check("t6_after_valid", rsp_valid, 1);
    check("t6_after_data", rsp_rdata, 32'hF00D);

    // flush in IDLE blocks acceptance
    op_valid = 1; op_vaddr = 32'h500; op_size = 2'b10; op_wr = 0; flush = 1;
    #1;
    check("idle_flush_ready", op_ready, 0);
    step();
    op_valid = 0; flush = 0;
    check("idle_flush_noreq", mem_req, 0);
    check("idle_flush_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
